// File: rtl/button_conditioner.sv
// button_conditioner: per-button synchroniser, debounce, press/release pulses
// and auto-repeat strobes; repeat logic is built only with BTN_AUTO_REPEAT_EN.
module button_conditioner #(
   parameter int N_BTN           = 5,
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic             MCLK,
   input  logic             rst,
   input  logic [N_BTN-1:0] button,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_repeat,
   output logic [N_BTN-1:0] btn_step
);

   localparam int DW =
      (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTO_REPEAT_EN
   localparam int R_MAX =
      (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HW = (R_MAX > 1) ? $clog2(R_MAX) : 1;
   localparam logic [HW-1:0] DLY_LAST = HW'(REPEAT_DELAY - 1);
   localparam logic [HW-1:0] PER_LAST = HW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HOLD,
      S_REPEAT
   } rpt_state_t;
`endif

   logic [N_BTN-1:0] s1;
   logic [N_BTN-1:0] s2;

   // Raw buttons are asynchronous to MCLK.
   always_ff @(posedge MCLK or posedge rst) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= button;
         s2 <= s1;
      end
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      logic [DW-1:0] dcnt;
      logic          level_q;
      logic          press_q;
      logic          release_q;
      logic          accept;
      logic          rise;
      logic          fall;

      // A level is accepted on the D-th consecutive mismatching cycle.
      assign accept = (s2[i] != level_q) && (dcnt == D_LAST);
      assign rise   = accept & s2[i];
      assign fall   = accept & ~s2[i];

      always_ff @(posedge MCLK or posedge rst) begin
         if (rst) begin
            dcnt      <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            press_q   <= rise;
            release_q <= fall;
            if (s2[i] == level_q) begin
               dcnt <= '0;
            end else if (accept) begin
               level_q <= s2[i];
               dcnt    <= '0;
            end else begin
               dcnt <= dcnt + DW'(1);
            end
         end
      end

      assign btn_level[i]   = level_q;
      assign btn_press[i]   = press_q;
      assign btn_release[i] = release_q;

`ifdef BTN_AUTO_REPEAT_EN
      rpt_state_t    st;
      logic [HW-1:0] hcnt;
      logic          rep_q;
      logic          step_q;

      // An accepted fall always wins, so repeat never coincides with release.
      always_ff @(posedge MCLK or posedge rst) begin
         if (rst) begin
            st     <= S_IDLE;
            hcnt   <= '0;
            rep_q  <= 1'b0;
            step_q <= 1'b0;
         end else begin
            rep_q  <= 1'b0;
            step_q <= rise;
            if (fall) begin
               st   <= S_IDLE;
               hcnt <= '0;
            end else begin
               unique case (st)
                  S_IDLE: begin
                     if (rise) begin
                        st   <= S_HOLD;
                        hcnt <= '0;
                     end
                  end
                  S_HOLD: begin
                     if (hcnt == DLY_LAST) begin
                        rep_q  <= 1'b1;
                        step_q <= 1'b1;
                        hcnt   <= '0;
                        st     <= S_REPEAT;
                     end else begin
                        hcnt <= hcnt + HW'(1);
                     end
                  end
                  S_REPEAT: begin
                     if (hcnt == PER_LAST) begin
                        rep_q  <= 1'b1;
                        step_q <= 1'b1;
                        hcnt   <= '0;
                     end else begin
                        hcnt <= hcnt + HW'(1);
                     end
                  end
                  default: begin
                     st   <= S_IDLE;
                     hcnt <= '0;
                  end
               endcase
            end
         end
      end

      assign btn_repeat[i] = rep_q;
      assign btn_step[i]   = step_q;
`else
      assign btn_repeat[i] = 1'b0;
      assign btn_step[i]   = press_q;
`endif
   end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scenario tasks plus a sliding-window reference
// model of debounce and held-time arithmetic for auto-repeat.
module tb_button_conditioner;

   localparam int N  = 5;
   localparam int D  = 4;
   localparam int RD = 20;
   localparam int RP = 5;
`ifdef BTN_AUTO_REPEAT_EN
   localparam bit REP_ON = 1'b1;
`else
   localparam bit REP_ON = 1'b0;
`endif

   logic         MCLK = 1'b0;
   logic         rst;
   logic [N-1:0] button;
   logic [N-1:0] btn_level;
   logic [N-1:0] btn_press;
   logic [N-1:0] btn_release;
   logic [N-1:0] btn_repeat;
   logic [N-1:0] btn_step;

   int tests = 0;
   int fails = 0;

   button_conditioner #(
      .N_BTN(N),
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .MCLK(MCLK),
      .rst(rst),
      .button(button),
      .btn_level(btn_level),
      .btn_press(btn_press),
      .btn_release(btn_release),
      .btn_repeat(btn_repeat),
      .btn_step(btn_step)
   );

   always #5 MCLK = ~MCLK;

   // Reference model: the level flips when the last D synchronised samples
   // (raw samples two edges old) all disagree with it; repeat from held time.
   logic [N-1:0] hist [$];
   logic [N-1:0] m_level, m_press, m_release, m_repeat, m_step;
   int held [N];
   bit flip;

   always @(posedge MCLK or posedge rst) begin
      if (rst) begin
         hist.delete();
         for (int j = 0; j < D + 2; j++) hist.push_front('0);
         m_level = '0; m_press = '0; m_release = '0;
         m_repeat = '0; m_step = '0;
         foreach (held[c]) held[c] = 0;
      end else begin
         hist.push_front(button);
         void'(hist.pop_back());
         m_press = '0; m_release = '0; m_repeat = '0;
         for (int c = 0; c < N; c++) begin
            flip = 1'b1;
            for (int j = 2; j < D + 2; j++)
               if (hist[j][c] == m_level[c]) flip = 1'b0;
            if (flip) begin
               m_level[c] = ~m_level[c];
               if (m_level[c]) begin
                  m_press[c] = 1'b1;
                  held[c] = 0;
               end else begin
                  m_release[c] = 1'b1;
               end
            end else if (m_level[c]) begin
               held[c]++;
               if (REP_ON && held[c] >= RD && (held[c] - RD) % RP == 0)
                  m_repeat[c] = 1'b1;
            end
         end
         m_step = m_press | m_repeat;
      end
   end

   wire [5*N-1:0] outs  = {btn_level, btn_press, btn_release, btn_repeat, btn_step};
   wire [5*N-1:0] mouts = {m_level, m_press, m_release, m_repeat, m_step};

   task automatic do_reset(input int cycles);
      @(negedge MCLK);
      rst = 1'b1;
      button = '0;
      repeat (cycles) @(negedge MCLK);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      int lvl_edge, presses, press_edge;
      @(negedge MCLK);
      rst = 1'b1;
      button = '0;
      button[0] = 1'b1;
      #1;
      tests++;
      if (outs !== '0) begin
         fails++;
         $display("FAIL reset_async: got %h expected 0", outs);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge MCLK);
         tests++;
         if (outs !== '0) begin
            fails++;
            $display("FAIL reset_hold cyc %0d: got %h expected 0", i, outs);
         end
      end
      rst = 1'b0;
      lvl_edge = -1; presses = 0; press_edge = -1;
      for (int e = 0; e < 12; e++) begin
         @(negedge MCLK);
         tests++;
         if (outs !== mouts) begin
            fails++;
            $display("FAIL reset_model e=%0d: got %h expected %h", e, outs, mouts);
         end
         if (btn_press[0]) begin presses++; press_edge = e; end
         if (btn_level[0] && lvl_edge < 0) lvl_edge = e;
      end
      tests++;
      if (lvl_edge !== D + 1) begin
         fails++;
         $display("FAIL reset_level_edge: got %0d expected %0d", lvl_edge, D + 1);
      end
      tests++;
      if (presses !== 1 || press_edge !== D + 1) begin
         fails++;
         $display("FAIL reset_press: got %0d pulses at %0d expected 1 at %0d",
                  presses, press_edge, D + 1);
      end
   endtask

   task automatic test_noise();
      int noisy, n, press_edge;
      do_reset(3);
      noisy = 0;
      for (int i = 0; i < 51; i++) begin
         @(negedge MCLK);
         tests++;
         if (outs !== mouts) begin
            fails++;
            $display("FAIL noise_model i=%0d: got %h expected %h", i, outs, mouts);
         end
         if (btn_press[0]) noisy++;
         button[0] = (i % 2 == 0);
         for (int c = 2; c < N; c++) button[c] = 1'($urandom_range(0, 1));
      end
      n = 0; press_edge = -1;
      for (int e = 0; e < 12; e++) begin
         @(negedge MCLK);
         tests++;
         if (outs !== mouts) begin
            fails++;
            $display("FAIL noise_model e=%0d: got %h expected %h", e, outs, mouts);
         end
         if (btn_press[0]) begin n++; press_edge = e; end
      end
      tests++;
      if (noisy !== 0) begin
         fails++;
         $display("FAIL noise_reject: got %0d presses expected 0", noisy);
      end
      tests++;
      if (n !== 1 || press_edge !== D + 1) begin
         fails++;
         $display("FAIL noise_press: got %0d at %0d expected 1 at %0d",
                  n, press_edge, D + 1);
      end
      tests++;
      if (btn_level[0] !== 1'b1) begin
         fails++;
         $display("FAIL noise_level: got %b expected 1", btn_level[0]);
      end
   endtask

   task automatic test_repeat();
      int offs[$];
      int exp_offs[$];
      int steps;
      bit found;
      do_reset(3);
      button[3] = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 4 * D && !found; k++) begin
         @(negedge MCLK);
         tests++;
         if (outs !== mouts) begin
            fails++;
            $display("FAIL repeat_model: got %h expected %h", outs, mouts);
         end
         if (btn_press[3]) found = 1'b1;
      end
      tests++;
      if (!found) begin
         fails++;
         $display("FAIL repeat_press_timeout: got none expected press");
      end
      steps = btn_step[3] ? 1 : 0;
      for (int off = 1; off < 40; off++) begin
         @(negedge MCLK);
         tests++;
         if (outs !== mouts) begin
            fails++;
            $display("FAIL repeat_model off=%0d: got %h expected %h", off, outs, mouts);
         end
         if (btn_repeat[3]) offs.push_back(off);
         if (btn_step[3]) steps++;
      end
      if (REP_ON)
         for (int t = RD; t < 40; t += RP) exp_offs.push_back(t);
      tests++;
      if (offs.size() !== exp_offs.size()) begin
         fails++;
         $display("FAIL repeat_count: got %0d expected %0d", offs.size(), exp_offs.size());
      end else begin
         foreach (exp_offs[k]) begin
            tests++;
            if (offs[k] !== exp_offs[k]) begin
               fails++;
               $display("FAIL repeat_offset %0d: got %0d expected %0d", k, offs[k], exp_offs[k]);
            end
         end
      end
      tests++;
      if (steps !== (REP_ON ? 5 : 1)) begin
         fails++;
         $display("FAIL repeat_steps: got %0d expected %0d", steps, REP_ON ? 5 : 1);
      end
   endtask

   task automatic test_release();
      int glitch_rel, n, rel_edge;
      bit found;
      do_reset(3);
      button[1] = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 4 * D + 3; k++) begin
         @(negedge MCLK);
         tests++;
         if (outs !== mouts) begin
            fails++;
            $display("FAIL release_model: got %h expected %h", outs, mouts);
         end
         if (btn_press[1]) found = 1'b1;
      end
      tests++;
      if (!found) begin
         fails++;
         $display("FAIL release_press_timeout: got none expected press");
      end
      glitch_rel = 0;
      for (int k = 0; k < 14; k++) begin
         @(negedge MCLK);
         tests++;
         if (outs !== mouts) begin
            fails++;
            $display("FAIL release_model k=%0d: got %h expected %h", k, outs, mouts);
         end
         if (btn_release[1]) glitch_rel++;
         button[1] = !(k < 3);
      end
      tests++;
      if (glitch_rel !== 0 || btn_level[1] !== 1'b1) begin
         fails++;
         $display("FAIL release_glitch: got %0d releases level %b expected 0 level 1",
                  glitch_rel, btn_level[1]);
      end
      button[1] = 1'b0;
      n = 0; rel_edge = -1;
      for (int e = 0; e < 12; e++) begin
         @(negedge MCLK);
         tests++;
         if (outs !== mouts) begin
            fails++;
            $display("FAIL release_model e=%0d: got %h expected %h", e, outs, mouts);
         end
         if (btn_release[1]) begin n++; rel_edge = e; end
      end
      tests++;
      if (n !== 1 || rel_edge !== D + 1 || btn_level[1] !== 1'b0) begin
         fails++;
         $display("FAIL release_edge: got %0d at %0d level %b expected 1 at %0d level 0",
                  n, rel_edge, btn_level[1], D + 1);
      end
   endtask

   task automatic test_simultaneous();
      int p0, p1;
      do_reset(3);
      button[1:0] = 2'b11;
      p0 = -1; p1 = -1;
      for (int e = 0; e < 12; e++) begin
         @(negedge MCLK);
         tests++;
         if (outs !== mouts) begin
            fails++;
            $display("FAIL simul_model e=%0d: got %h expected %h", e, outs, mouts);
         end
         if (btn_press[0]) p0 = e;
         if (btn_press[1]) p1 = e;
      end
      tests++;
      if (p0 !== D + 1 || p1 !== D + 1) begin
         fails++;
         $display("FAIL simul_press: got %0d/%0d expected %0d/%0d", p0, p1, D + 1, D + 1);
      end
   endtask

   task automatic test_midhold_reset();
      int reps, press_edge;
      bit found;
      do_reset(3);
      button[2] = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 4 * D && !found; k++) begin
         @(negedge MCLK);
         if (btn_press[2]) found = 1'b1;
      end
      tests++;
      if (!found) begin
         fails++;
         $display("FAIL midhold_press_timeout: got none expected press");
      end
      for (int k = 0; k < RD + RP + 2; k++) begin
         @(negedge MCLK);
         tests++;
         if (outs !== mouts) begin
            fails++;
            $display("FAIL midhold_model k=%0d: got %h expected %h", k, outs, mouts);
         end
      end
      #2 rst = 1'b1;
      #1;
      tests++;
      if (outs !== '0) begin
         fails++;
         $display("FAIL midhold_async: got %h expected 0", outs);
      end
      @(negedge MCLK);
      tests++;
      if (outs !== '0) begin
         fails++;
         $display("FAIL midhold_in_reset: got %h expected 0", outs);
      end
      rst = 1'b0;
      reps = 0; press_edge = -1;
      for (int e = 0; e < 12; e++) begin
         @(negedge MCLK);
         tests++;
         if (outs !== mouts) begin
            fails++;
            $display("FAIL midhold_model e=%0d: got %h expected %h", e, outs, mouts);
         end
         if (btn_repeat[2]) reps++;
         if (btn_press[2]) press_edge = e;
      end
      tests++;
      if (reps !== 0 || press_edge !== D + 1) begin
         fails++;
         $display("FAIL midhold_after: got %0d repeats press at %0d expected 0 at %0d",
                  reps, press_edge, D + 1);
      end
   endtask

   task automatic test_random();
      int run [N];
      do_reset(3);
      foreach (run[c]) run[c] = 0;
      for (int i = 0; i < 1500; i++) begin
         @(negedge MCLK);
         tests++;
         if (outs !== mouts) begin
            fails++;
            $display("FAIL random_model i=%0d: got %h expected %h", i, outs, mouts);
         end
         rst = ($urandom_range(0, 399) == 0);
         for (int c = 0; c < N; c++) begin
            if (run[c] == 0) begin
               button[c] = 1'($urandom_range(0, 1));
               run[c] = ($urandom_range(0, 3) == 0) ?
                        int'($urandom_range(20, 45)) : int'($urandom_range(1, 8));
            end else begin
               run[c]--;
            end
         end
      end
      @(negedge MCLK);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      button = '0;
      test_reset();
      test_noise();
      test_repeat();
      test_release();
      test_simultaneous();
      test_midhold_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
